fft4_stream: RTL and testbench
==============================

// Module: fft4_stream
// PURPOSE
//  Streaming 4-point forward FFT (DIT radix-2, two butterfly stages); forward counterpart of the 4-point IFFT.
//  Accepts 4 complex time samples serially (valid/ready), computes X[k]=sum x[n]*W4^(nk), W4^1=-j.
//  Emits 4 frequency bins serially in natural order k=0..3 with valid/ready backpressure.
//  Sits between sample source and IFFT/spectral processing; twiddles trivial (swap/negate), no multipliers.
// PARAMETERS
//  DATA_WIDTH  8  signed input width per real/imag component; output width DATA_WIDTH+2
// PORTS
//  clk        in   1             clock, all state updates on rising edge
//  rst_n      in   1             asynchronous active-low reset
//  in_valid   in   1             input sample valid
//  in_ready   out  1             block can accept a sample
//  in_real    in   DATA_WIDTH    signed real part of x[n]
//  in_imag    in   DATA_WIDTH    signed imag part of x[n]
//  out_valid  out  1             output bin valid
//  out_ready  in   1             sink accepts bin
//  out_real   out  DATA_WIDTH+2  signed real part of X[k]
//  out_imag   out  DATA_WIDTH+2  signed imag part of X[k]
//  out_index  out  2             bin index k of current output beat
//  out_last   out  1             high with out_valid when out_index==3
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOAD, sample cnt=0, in_ready=1, out_valid=0, out_real/imag=0, out_index=0, out_last=0; sample/stage regs cleared.
//  Handshakes: input beat on in_valid&in_ready; output beat on out_valid&out_ready. in_ready, out_valid driven from registered state only.
//  FSM: LOAD -> S1 -> S2 -> OUT -> LOAD.
//   LOAD: in_ready=1; beat n stored to x[n], cnt++; on 4th beat (cnt==3) -> S1, cnt=0.
//   S1: in_ready=0; register stage1 (DATA_WIDTH+1): a0=x0+x2, a1=x0-x2, b0=x1+x3, b1=x1-x3 (re/im each). -> S2.
//   S2: register stage2 (DATA_WIDTH+2): X0=a0+b0; X2=a0-b0;
//       X1.re=a1.re+b1.im, X1.im=a1.im-b1.re; X3.re=a1.re-b1.im, X3.im=a1.im+b1.re. -> OUT.
//   OUT: out_valid=1, out_index starts 0; index++ per output beat; beat with index 3 -> LOAD, in_ready=1 next cycle.
//  Latency: last input beat in cycle N -> first out_valid in cycle N+3; 4 output beats min; frame period min 4+2+4=10 cycles.
//  Backpressure: out_valid=1 & out_ready=0 holds out_real/imag/index/last stable; no loss, no timeout.
//  in_valid during S1/S2/OUT ignored (in_ready=0); source must hold its data.
//  Arithmetic: sign-extend before every add/sub; no saturation needed: full-scale inputs fit DATA_WIDTH+2 exactly
//   (all -2^(DW-1) -> X0=-2^(DW+1)).
//  Partial frame (1-3 samples) waits indefinitely in LOAD; no timeout, no flush.
//  rst_n asserted mid-frame or mid-output: immediate abort, all state to reset values, partial frame discarded.
// CONFIGURATION
//  FFT4_SCALE_EN defined: S2 outputs arithmetic-shifted right 2 (floor) before output register, i.e. X[k]/4;
//   sign extended to DATA_WIDTH+2; latency unchanged.
//  Not defined: unscaled X[k], full DATA_WIDTH+2 growth.
// TESTING
//  Impulse x=[1,0,0,0] (imag 0) -> bins k0..3 = (1,0),(1,0),(1,0),(1,0); out_last only on k=3.
//  DC x=[1,1,1,1] -> (4,0),(0,0),(0,0),(0,0); with FFT4_SCALE_EN -> (1,0),(0,0),(0,0),(0,0).
//  Shifted impulse x=[0,1,0,0] -> (1,0),(0,-1),(-1,0),(0,1); checks W4=-j sign.
//  Full scale DW=8, all x=(-128,-128) -> X0=(-512,-512), others (0,0); no wrap.
//  Backpressure: out_ready=0 for 5 cycles at k=1 -> out_index=1, data stable; in_ready stays 0; resume k=2,3.
//  Reset mid-OUT at k=2 -> out_valid=0 same cycle, in_ready=1; next frame [2,0,0,0] -> all bins (2,0).

Source files
------------

// File: rtl/fft4_stream.sv
// Streaming 4-point forward FFT (radix-2 DIT): load 4 samples, two registered butterfly
// stages, then stream bins k=0..3. Define FFT4_SCALE_EN to emit X[k]/4 (floor) instead of X[k].
module fft4_stream #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_real,
   input  logic signed [DATA_WIDTH-1:0] in_imag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH+1:0] out_real,
   output logic signed [DATA_WIDTH+1:0] out_imag,
   output logic [1:0]                   out_index,
   output logic                         out_last
);

   localparam int W1 = DATA_WIDTH + 1;
   localparam int W2 = DATA_WIDTH + 2;

   typedef enum logic [1:0] {ST_LOAD, ST_S1, ST_S2, ST_OUT} state_e;

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] idx_q, idx_d;

   logic signed [DATA_WIDTH-1:0] x_re_q [4];
   logic signed [DATA_WIDTH-1:0] x_im_q [4];
   // Stage-1 slots: 0=a0 (x0+x2), 1=a1 (x0-x2), 2=b0 (x1+x3), 3=b1 (x1-x3)
   logic signed [W1-1:0] s1_re_q [4], s1_re_d [4];
   logic signed [W1-1:0] s1_im_q [4], s1_im_d [4];
   logic signed [W2-1:0] s2_re_q [4], s2_re_d [4];
   logic signed [W2-1:0] s2_im_q [4], s2_im_d [4];
   logic signed [W2-1:0] full_re [4], full_im [4];

   function automatic logic signed [W1-1:0] sx1(input logic signed [DATA_WIDTH-1:0] v);
      return {v[DATA_WIDTH-1], v};
   endfunction

   function automatic logic signed [W2-1:0] sx2(input logic signed [W1-1:0] v);
      return {v[W1-1], v};
   endfunction

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_LOAD: if (in_valid) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = ST_S1;
         end
         ST_S1:   state_d = ST_S2;
         ST_S2:   state_d = ST_OUT;
         ST_OUT:  if (out_ready) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      s1_re_d[0] = sx1(x_re_q[0]) + sx1(x_re_q[2]);
      s1_im_d[0] = sx1(x_im_q[0]) + sx1(x_im_q[2]);
      s1_re_d[1] = sx1(x_re_q[0]) - sx1(x_re_q[2]);
      s1_im_d[1] = sx1(x_im_q[0]) - sx1(x_im_q[2]);
      s1_re_d[2] = sx1(x_re_q[1]) + sx1(x_re_q[3]);
      s1_im_d[2] = sx1(x_im_q[1]) + sx1(x_im_q[3]);
      s1_re_d[3] = sx1(x_re_q[1]) - sx1(x_re_q[3]);
      s1_im_d[3] = sx1(x_im_q[1]) - sx1(x_im_q[3]);

      // The W4^1 = -j twiddle on b1 is a real/imag swap with one negation.
      full_re[0] = sx2(s1_re_q[0]) + sx2(s1_re_q[2]);
      full_im[0] = sx2(s1_im_q[0]) + sx2(s1_im_q[2]);
      full_re[1] = sx2(s1_re_q[1]) + sx2(s1_im_q[3]);
      full_im[1] = sx2(s1_im_q[1]) - sx2(s1_re_q[3]);
      full_re[2] = sx2(s1_re_q[0]) - sx2(s1_re_q[2]);
      full_im[2] = sx2(s1_im_q[0]) - sx2(s1_im_q[2]);
      full_re[3] = sx2(s1_re_q[1]) - sx2(s1_im_q[3]);
      full_im[3] = sx2(s1_im_q[1]) + sx2(s1_re_q[3]);

      for (int k = 0; k < 4; k++) begin
`ifdef FFT4_SCALE_EN
         s2_re_d[k] = full_re[k] >>> 2;
         s2_im_d[k] = full_im[k] >>> 2;
`else
         s2_re_d[k] = full_re[k];
         s2_im_d[k] = full_im[k];
`endif
      end
   end

   // NOTE: the small sample/stage arrays are reset too, so outputs read zero straight after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            x_re_q[k]  <= '0;
            x_im_q[k]  <= '0;
            s1_re_q[k] <= '0;
            s1_im_q[k] <= '0;
            s2_re_q[k] <= '0;
            s2_im_q[k] <= '0;
         end
      end else begin
         if (state_q == ST_LOAD && in_valid) begin
            x_re_q[cnt_q] <= in_real;
            x_im_q[cnt_q] <= in_imag;
         end
         if (state_q == ST_S1) begin
            s1_re_q <= s1_re_d;
            s1_im_q <= s1_im_d;
         end
         if (state_q == ST_S2) begin
            s2_re_q <= s2_re_d;
            s2_im_q <= s2_im_d;
         end
      end
   end

   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_OUT);
   assign out_index = idx_q;
   assign out_last  = out_valid && (idx_q == 2'd3);
   assign out_real  = s2_re_q[idx_q];
   assign out_imag  = s2_im_q[idx_q];

endmodule

// File: tb/tb_fft4_stream.sv
// Self-checking bench for fft4_stream: direct DFT model with a per-beat scoreboard,
// plus literal bin checks, latency, partial frame, backpressure and mid-output reset.
module tb_fft4_stream;

   localparam int DW = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] in_real = '0;
   logic signed [DW-1:0] in_imag = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic signed [DW+1:0] out_real;
   logic signed [DW+1:0] out_imag;
   logic [1:0]           out_index;
   logic                 out_last;

   fft4_stream #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
      .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
      .out_index(out_index), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {int re; int im; int k;} bin_t;
   bin_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int rx_re[4];
   int rx_im[4];
   int rx_n = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: X[k] = sum x[n] * (-j)^(n*k), optionally floor-divided by 4.
   task automatic push_model(input int xr[4], input int xi[4]);
      for (int k = 0; k < 4; k++) begin
         bin_t b;
         int sr = 0;
         int si = 0;
         for (int n = 0; n < 4; n++) begin
            case ((n * k) % 4)
               0: begin sr += xr[n]; si += xi[n]; end
               1: begin sr += xi[n]; si -= xr[n]; end
               2: begin sr -= xr[n]; si -= xi[n]; end
               default: begin sr -= xi[n]; si += xr[n]; end
            endcase
         end
`ifdef FFT4_SCALE_EN
         sr = sr >>> 2;
         si = si >>> 2;
`endif
         b.re = sr; b.im = si; b.k = k;
         exp_q.push_back(b);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_beat: got index %0d expected no beat", out_index);
         end else begin
            bin_t e;
            e = exp_q.pop_front();
            check($sformatf("bin%0d_re", e.k), int'(out_real), e.re);
            check($sformatf("bin%0d_im", e.k), int'(out_imag), e.im);
            check($sformatf("bin%0d_index", e.k), int'(out_index), e.k);
            check($sformatf("bin%0d_last", e.k), int'(out_last), (e.k == 3) ? 1 : 0);
            rx_re[out_index] = int'(out_real);
            rx_im[out_index] = int'(out_imag);
            rx_n++;
         end
      end
   end

   task automatic send_sample(input int re, input int im);
      int t = 0;
      in_valid = 1'b1;
      in_real  = DW'(re);
      in_imag  = DW'(im);
      forever begin
         @(negedge clk);
         if (in_ready) break;
         if (++t > 100) begin
            $display("FAIL in_ready_timeout: got 0 expected 1");
            $fatal(1, "input handshake never completed");
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int xr[4], input int xi[4]);
      rx_n = 0;
      for (int n = 0; n < 4; n++) send_sample(xr[n], xi[n]);
      push_model(xr, xi);
   endtask

   task automatic wait_frame(input string tag);
      int t = 0;
      while (rx_n < 4 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      check({tag, "_beats"}, rx_n, 4);
      check({tag, "_in_ready_after"}, int'(in_ready), 1);
   endtask

   task automatic check_rx(input string tag, input int er[4], input int ei[4]);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_lit_re%0d", tag, k), rx_re[k], er[k]);
         check($sformatf("%s_lit_im%0d", tag, k), rx_im[k], ei[k]);
      end
   endtask

   int xr[4], xi[4], er[4], ei[4];
   int lat, held_re, held_im, t;

   initial begin
      #12;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_real", int'(out_real), 0);
      check("rst_out_imag", int'(out_imag), 0);
      check("rst_out_index", int'(out_index), 0);
      check("rst_out_last", int'(out_last), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Impulse, with first-output latency measurement
      xr = '{1, 0, 0, 0}; xi = '{0, 0, 0, 0};
      send_frame(xr, xi);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check("latency", lat, 3);
      wait_frame("impulse");
`ifdef FFT4_SCALE_EN
      er = '{0, 0, 0, 0}; ei = '{0, 0, 0, 0};
`else
      er = '{1, 1, 1, 1}; ei = '{0, 0, 0, 0};
`endif
      check_rx("impulse", er, ei);

      // DC
      xr = '{1, 1, 1, 1}; xi = '{0, 0, 0, 0};
      send_frame(xr, xi);
      wait_frame("dc");
`ifdef FFT4_SCALE_EN
      er = '{1, 0, 0, 0}; ei = '{0, 0, 0, 0};
`else
      er = '{4, 0, 0, 0}; ei = '{0, 0, 0, 0};
`endif
      check_rx("dc", er, ei);

      // Shifted impulse under backpressure at k=1
      out_ready = 1'b0;
      xr = '{0, 1, 0, 0}; xi = '{0, 0, 0, 0};
      send_frame(xr, xi);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!out_valid && t < 20);
      check("bp_valid_seen", int'(out_valid), 1);
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      held_re = int'(out_real);
      held_im = int'(out_imag);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_index", int'(out_index), 1);
         check("bp_valid", int'(out_valid), 1);
         check("bp_re_stable", int'(out_real), held_re);
         check("bp_im_stable", int'(out_imag), held_im);
         check("bp_in_ready", int'(in_ready), 0);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      wait_frame("shift");
`ifdef FFT4_SCALE_EN
      er = '{0, 0, -1, 0}; ei = '{0, -1, 0, 0};
`else
      er = '{1, 0, -1, 0}; ei = '{0, -1, 0, 1};
`endif
      check_rx("shift", er, ei);

      // Full scale negative
      xr = '{-128, -128, -128, -128}; xi = '{-128, -128, -128, -128};
      send_frame(xr, xi);
      wait_frame("fullscale");
`ifdef FFT4_SCALE_EN
      er = '{-128, 0, 0, 0}; ei = '{-128, 0, 0, 0};
`else
      er = '{-512, 0, 0, 0}; ei = '{-512, 0, 0, 0};
`endif
      check_rx("fullscale", er, ei);

      // Mixed complex frame delivered as a stalled partial frame
      xr = '{3, -5, 100, -128}; xi = '{-2, 7, -60, 127};
      rx_n = 0;
      send_sample(xr[0], xi[0]);
      send_sample(xr[1], xi[1]);
      repeat (12) @(posedge clk);
      #1;
      check("partial_out_valid", int'(out_valid), 0);
      check("partial_in_ready", int'(in_ready), 1);
      send_sample(xr[2], xi[2]);
      send_sample(xr[3], xi[3]);
      push_model(xr, xi);
      wait_frame("mixed");

      // Reset while holding bin k=2
      xr = '{5, 2, 0, 7}; xi = '{1, 3, -4, 7};
      send_frame(xr, xi);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(out_valid && out_index == 2'd1) && t < 20);
      @(posedge clk); #1; out_ready = 1'b0;
      check("pre_rst_index", int'(out_index), 2);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_out_index", int'(out_index), 0);
      check("midrst_out_real", int'(out_real), 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      xr = '{2, 0, 0, 0}; xi = '{0, 0, 0, 0};
      send_frame(xr, xi);
      wait_frame("post_rst");
`ifdef FFT4_SCALE_EN
      er = '{0, 0, 0, 0}; ei = '{0, 0, 0, 0};
`else
      er = '{2, 2, 2, 2}; ei = '{0, 0, 0, 0};
`endif
      check_rx("post_rst", er, ei);

      check("leftover_expected", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
